// File: rtl/alu_result_display_if.sv
// Bundle of the signals between the ALU-result display block and its neighbours.
//   load        : start a conversion of r_in (accepted only while idle)
//   r_in        : 8-bit ALU result
//   signed_mode : 1 = r_in is two's complement, 0 = unsigned
//   busy        : conversion in progress
//   an          : active-low one-hot digit enables (0 ones, 1 tens, 2 hundreds, 3 sign)
//   seg         : active-low segments, g..a
//   dp          : active-low decimal point (always off)
// master : the producer side (drives load/r_in/signed_mode, observes the display pins)
// slave  : the display block itself
interface alu_result_display_if;
    logic       load;
    logic [7:0] r_in;
    logic       signed_mode;
    logic       busy;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    modport master (
        output load, r_in, signed_mode,
        input  busy, an, seg, dp
    );

    modport slave (
        input  load, r_in, signed_mode,
        output busy, an, seg, dp
    );
endinterface

// File: rtl/alu_result_display.sv
// Captures an 8-bit ALU result, converts it to sign + three BCD digits with a serial
// shift-and-add-3 engine (one iteration per clock), and scans the result onto a
// 4-digit multiplexed common-anode 7-segment display.
// Ports:
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset
//   ifc : alu_result_display_if.slave (load, r_in, signed_mode in; busy, an, seg, dp out)
// Parameters:
//   REFRESH_DIV : cycles each digit stays lit (>= 2)
module alu_result_display #(
    parameter int unsigned REFRESH_DIV = 50000
) (
    input logic                   clk,
    input logic                   rst,
    alu_result_display_if.slave   ifc
);

    typedef enum logic [1:0] {StIdle, StShift, StCommit} state_e;

    localparam int unsigned     CntW   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(REFRESH_DIV - 1);

    localparam logic [6:0] SegBlank = 7'b1111111;
    localparam logic [6:0] SegMinus = 7'b0111111;

    // Converter state
    state_e      state_q;
    logic        busy_q;
    logic [7:0]  mag_q;
    logic [11:0] bcd_q;
    logic [2:0]  iter_q;
    logic        neg_q;

    // Display registers: the only converter state the scanner looks at
    logic [11:0] disp_bcd_q;
    logic        disp_neg_q;

    // Scanner state
    logic [CntW-1:0] refresh_cnt_q;
    logic [1:0]      digit_q;
    logic [3:0]      an_q;
    logic [6:0]      seg_q;

    // Combinational helpers
    logic        neg_in;
    logic [7:0]  mag_in;
    logic [11:0] bcd_adj;
    logic [19:0] shift_val;
    logic [1:0]  digit_nxt;
    logic [3:0]  an_d;
    logic [6:0]  seg_d;
    logic [3:0]  hund;
    logic [3:0]  tens;
    logic [3:0]  ones;

    function automatic logic [3:0] add3(input logic [3:0] nib);
        return (nib >= 4'd5) ? nib + 4'd3 : nib;
    endfunction

    function automatic logic [6:0] glyph(input logic [3:0] d);
        logic [6:0] g;
        case (d)
            4'd0:    g = 7'b1000000;
            4'd1:    g = 7'b1111001;
            4'd2:    g = 7'b0100100;
            4'd3:    g = 7'b0110000;
            4'd4:    g = 7'b0011001;
            4'd5:    g = 7'b0010010;
            4'd6:    g = 7'b0000010;
            4'd7:    g = 7'b1111000;
            4'd8:    g = 7'b0000000;
            4'd9:    g = 7'b0010000;
            default: g = SegBlank;
        endcase
        return g;
    endfunction

    always_comb begin
        neg_in = ifc.signed_mode & ifc.r_in[7];
        // 8-bit negate is enough: -128 wraps to 8'h80, which read unsigned is 128.
        mag_in = neg_in ? (8'd0 - ifc.r_in) : ifc.r_in;

        bcd_adj   = {add3(bcd_q[11:8]), add3(bcd_q[7:4]), add3(bcd_q[3:0])};
        shift_val = {bcd_adj, mag_q} << 1;
    end

    // Conversion FSM; busy is registered so it rises on the accepting edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            busy_q     <= 1'b0;
            mag_q      <= 8'd0;
            bcd_q      <= 12'd0;
            iter_q     <= 3'd0;
            neg_q      <= 1'b0;
            disp_bcd_q <= 12'd0;
            disp_neg_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (ifc.load) begin
                        mag_q   <= mag_in;
                        neg_q   <= neg_in;
                        bcd_q   <= 12'd0;
                        iter_q  <= 3'd0;
                        busy_q  <= 1'b1;
                        state_q <= StShift;
                    end
                end
                StShift: begin
                    bcd_q  <= shift_val[19:8];
                    mag_q  <= shift_val[7:0];
                    iter_q <= iter_q + 3'd1;
                    if (iter_q == 3'd7) begin
                        state_q <= StCommit;
                    end
                end
                StCommit: begin
                    disp_bcd_q <= bcd_q;
                    disp_neg_q <= neg_q;
                    busy_q     <= 1'b0;
                    state_q    <= StIdle;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Next digit's enable and glyph, loaded together on the wrap edge.
    always_comb begin
        hund      = disp_bcd_q[11:8];
        tens      = disp_bcd_q[7:4];
        ones      = disp_bcd_q[3:0];
        digit_nxt = digit_q + 2'd1;
        an_d      = ~(4'b0001 << digit_nxt);
        seg_d     = SegBlank;
        unique case (digit_nxt)
            2'd0: seg_d = glyph(ones);
            2'd1: seg_d = ((hund == 4'd0) && (tens == 4'd0)) ? SegBlank : glyph(tens);
            2'd2: seg_d = (hund == 4'd0) ? SegBlank : glyph(hund);
            2'd3: seg_d = disp_neg_q ? SegMinus : SegBlank;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            refresh_cnt_q <= '0;
            digit_q       <= 2'd0;
            an_q          <= 4'b1110;
            seg_q         <= 7'b1000000;
        end else if (refresh_cnt_q == CntMax) begin
            refresh_cnt_q <= '0;
            digit_q       <= digit_nxt;
            an_q          <= an_d;
            seg_q         <= seg_d;
        end else begin
            refresh_cnt_q <= refresh_cnt_q + CntW'(1);
        end
    end

    assign ifc.busy = busy_q;
    assign ifc.an   = an_q;
    assign ifc.seg  = seg_q;
    assign ifc.dp   = 1'b1;

endmodule

// File: tb/tb_alu_result_display.sv
// Randomised self-checking bench for alu_result_display against a decimal-arithmetic model.
module tb_alu_result_display;

    localparam int unsigned RD = 4;

    logic clk;
    logic rst;

    alu_result_display_if ifc ();

    alu_result_display #(.REFRESH_DIV(RD)) dut (
        .clk (clk),
        .rst (rst),
        .ifc (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model of what the display should show
    int model_val = 0;
    bit model_neg = 1'b0;

    logic [6:0] glyph_tab [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };
    localparam logic [6:0] Blank = 7'b1111111;
    localparam logic [6:0] Minus = 7'b0111111;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic void set_model(input logic [7:0] v, input bit sm);
        if (sm && v[7]) begin
            model_val = 256 - int'(v);
            model_neg = 1'b1;
        end else begin
            model_val = int'(v);
            model_neg = 1'b0;
        end
    endfunction

    function automatic logic [6:0] exp_seg(input int idx);
        int h, t, o;
        h = model_val / 100;
        t = (model_val / 10) % 10;
        o = model_val % 10;
        case (idx)
            0:       return glyph_tab[o];
            1:       return (h == 0 && t == 0) ? Blank : glyph_tab[t];
            2:       return (h == 0) ? Blank : glyph_tab[h];
            default: return model_neg ? Minus : Blank;
        endcase
    endfunction

    // Load v at edge k, optionally pulse a second load before edge k+inj_edge,
    // and check busy on every edge up to the commit at k+9.
    task automatic run_load(input logic [7:0] v, input bit sm, input int inj_edge,
                            input logic [7:0] inj_val);
        @(negedge clk);
        ifc.load        = 1'b1;
        ifc.r_in        = v;
        ifc.signed_mode = sm;
        @(posedge clk);
        #1;
        check("busy_start", ifc.busy, 1);
        for (int j = 1; j <= 9; j++) begin
            @(negedge clk);
            ifc.load = (j == inj_edge);
            if (j == inj_edge) ifc.r_in = inj_val;
            @(posedge clk);
            #1;
            check("busy_run", ifc.busy, (j < 9) ? 1 : 0);
        end
        ifc.load = 1'b0;
    endtask

    // Let the new value reach every digit, then watch one whole frame.
    task automatic check_frame(input string tag);
        int idx;
        repeat (4 * RD) @(posedge clk);
        for (int c = 0; c < int'(4 * RD); c++) begin
            @(negedge clk);
            idx = -1;
            for (int i = 3; i >= 0; i--) if (ifc.an[i] == 1'b0) idx = i;
            check({tag, "_an_onehot"}, $countones(ifc.an), 3);
            if (idx >= 0) check({tag, "_seg"}, ifc.seg, exp_seg(idx));
        end
        check({tag, "_dp"}, ifc.dp, 1);
    endtask

    initial begin
        logic [3:0] an_exp;
        logic [7:0] v;
        bit         sm;

        rst             = 1'b1;
        ifc.load        = 1'b0;
        ifc.r_in        = 8'd0;
        ifc.signed_mode = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_an", ifc.an, 4'b1110);
        check("rst_seg", ifc.seg, 7'b1000000);
        check("rst_busy", ifc.busy, 0);
        check("rst_dp", ifc.dp, 1);
        @(negedge clk);
        rst = 1'b0;

        // Unsigned 200
        run_load(8'd200, 1'b0, 0, 8'd0);
        set_model(8'd200, 1'b0);
        check_frame("u200");

        // Mid-cycle asynchronous reset, then scan sequence
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_an", ifc.an, 4'b1110);
        check("arst_seg", ifc.seg, 7'b1000000);
        check("arst_busy", ifc.busy, 0);
        set_model(8'd0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        for (int n = 1; n <= 16; n++) begin
            @(posedge clk);
            #1;
            an_exp = ~(4'b0001 << ((n / 4) % 4));
            check("scan_an", ifc.an, an_exp);
            check("scan_seg", ifc.seg, exp_seg((n / 4) % 4));
        end

        // Signed -10, -128, then unsigned 7
        run_load(8'hF6, 1'b1, 0, 8'd0);
        set_model(8'hF6, 1'b1);
        check_frame("s_m10");
        run_load(8'h80, 1'b1, 0, 8'd0);
        set_model(8'h80, 1'b1);
        check_frame("s_m128");
        run_load(8'd7, 1'b0, 0, 8'd0);
        set_model(8'd7, 1'b0);
        check_frame("u7");

        // Load while busy is dropped; the next load at k+10 is taken
        run_load(8'd99, 1'b0, 3, 8'd55);
        set_model(8'd99, 1'b0);
        check_frame("busy_ign");
        run_load(8'd42, 1'b0, 0, 8'd0);
        set_model(8'd42, 1'b0);
        run_load(8'd55, 1'b0, 0, 8'd0);
        set_model(8'd55, 1'b0);
        check_frame("u55");

        // Reset mid-conversion abandons it
        run_load(8'd42, 1'b0, 0, 8'd0);
        set_model(8'd42, 1'b0);
        check_frame("u42");
        @(negedge clk);
        ifc.load = 1'b1;
        ifc.r_in = 8'd255;
        @(posedge clk);
        @(negedge clk);
        ifc.load = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("mid_rst_busy", ifc.busy, 0);
        check("mid_rst_an", ifc.an, 4'b1110);
        check("mid_rst_seg", ifc.seg, 7'b1000000);
        set_model(8'd0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("mid_rst_idle", ifc.busy, 0);
        check_frame("after_rst");

        // Randomised values in both modes
        for (int r = 0; r < 12; r++) begin
            v  = 8'($urandom_range(0, 255));
            sm = 1'($urandom_range(0, 1));
            run_load(v, sm, 0, 8'd0);
            set_model(v, sm);
            check_frame("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Watchdog so the run always ends
    initial begin
        #2000000;
        $display("FAIL watchdog: timeout got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
